uart_rcv: RTL



---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rcv_shift_parity.sv | 21 ++
 rtl/uart_rcv.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and receiver state type shared by the UART transmit and receive sides
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rcv_state_t;
    localparam int DATA_BITS = 8;
    localparam bit PARITY_EVEN = 1'b1;
endpackage

// File: rtl/uart_rcv_shift_parity.sv
// rcv_shift_parity: LSB-first right-shift register with a running XOR of every bit shifted in
module rcv_shift_parity
    import uart_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Enable,
    input  logic                 Din,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Parity
);
    always_ff @(posedge Clock) begin
        if (Clear) begin
            Dout   <= '0;
            Parity <= 1'b0;
        end else if (Enable) begin
            Dout   <= {Din, Dout[DATA_BITS-1:1]};
            Parity <= Parity ^ Din;
        end
    end
endmodule

// File: rtl/uart_rcv.sv
// uart_rcv: oversampling UART receiver (start, 8 data LSB first, even parity, stop) with a ready/read CPU handshake
module uart_rcv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RxD,
    input  logic        RD,
    output logic [31:0] Dout,
    output logic        RxRDY,
    output logic        PE,
    output logic        FE,
    output logic        OE
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    rcv_state_t state, state_n;
    logic [1:0] sync;
    logic rxs, tick, mid, cnt_clr, clr, shift, done, perr, acc;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    assign rxs  = sync[1];
    assign tick = cnt == LAST;
    assign mid  = cnt == MID;
    rcv_shift_parity u_shift (
        .Clock  (Clock),
        .Clear  (clr | ~Reset),
        .Enable (shift),
        .Din    (rxs),
        .Dout   (shreg),
        .Parity (acc)
    );
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync    <= 2'b11;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            perr    <= 1'b0;
        end else begin
            sync    <= {sync[0], RxD};
            state   <= state_n;
            cnt     <= (cnt_clr || tick) ? '0 : cnt + CW'(1);
            bit_cnt <= clr ? '0 : bit_cnt + 3'(shift);
            if (state == PARITY && tick)
                perr <= rxs ^ acc ^ !PARITY_EVEN;
        end
    end
    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        clr     = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                state_n = rxs ? IDLE : START;
            end
            START: if (mid) begin
                cnt_clr = 1'b1;
                clr     = !rxs;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shift   = 1'b1;
                state_n = (bit_cnt == 3'(DATA_BITS - 1)) ? PARITY : DATA;
            end
            PARITY: state_n = tick ? STOP : PARITY;
            STOP: if (tick) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // a completion in the same cycle as RD wins over the read-clear
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Dout  <= '0;
            RxRDY <= 1'b0;
            PE    <= 1'b0;
            FE    <= 1'b0;
            OE    <= 1'b0;
        end else if (done) begin
            Dout  <= {{(32 - DATA_BITS){1'b0}}, shreg};
            PE    <= perr;
            FE    <= ~rxs;
            OE    <= RxRDY & ~RD;
            RxRDY <= 1'b1;
        end else if (RD) begin
            RxRDY <= 1'b0;
            PE    <= 1'b0;
            FE    <= 1'b0;
            OE    <= 1'b0;
        end
    end
endmodule
